pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Program counter and instruction fetch stage of the picoMIPS core. It sits directly upstream of the decoder.
//  - Drives the synchronous program ROM address.
//  - Presents the fetched word and its top-4-bit opcode to the decoder.
//  - Updates the PC from the decoder's PCincr/PCabsbranch/PCrelbranch controls.
//  - Inserts a NOP fill cycle after reset, and traps jump-to-self as a halt.
// PARAMETERS
//  PSIZE  6   PC / program address width (program depth 2**PSIZE words)
//  ISIZE  16  instruction width; opcode = instr[ISIZE-1 -: 4]
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  reset        in   1      asynchronous, active-high reset
//  PCincr       in   1      decoder: pc <= pc + 1
//  PCabsbranch  in   1      decoder: pc <= baddr
//  PCrelbranch  in   1      decoder: pc <= pc + baddr (baddr two's complement)
//  baddr        in   PSIZE  branch target (abs) or signed offset (rel)
//  prog_data    in   ISIZE  ROM read data, 1-cycle registered-address read
//  prog_addr    out  PSIZE  ROM address (combinational next-PC)
//  instr        out  ISIZE  current instruction to decoder/datapath
//  opcode       out  4      instr[ISIZE-1:ISIZE-4]
//  pc           out  PSIZE  address of the current instr
//  ivalid       out  1      instr is a real fetched word (not fill/halt NOP)
//  halted       out  1      core trapped in HALT
// BEHAVIOUR
//  - Reset (async, any time incl. mid-branch or in HALT):
//    - pc=0, state=FILL, halted=0.
//    - instr={4'b1111,0} (NOP), ivalid=0, prog_addr=0.
//  - States: FILL -> RUN -> HALT. HALT is left only by reset.
//  - FILL: lasts exactly one cycle after reset release.
//    - Outputs as at reset; decoder controls are ignored.
//    - prog_addr=0, so ROM holds mem[0] at the next edge; pc stays 0; go to RUN.
//  - RUN:
//    - instr=prog_data (== mem[pc]), ivalid=1.
//    - Next-PC priority: PCabsbranch > PCrelbranch > PCincr > hold (pc_nxt=pc).
//    - prog_addr=pc_nxt (combinational); pc<=pc_nxt at edge. This gives a zero-penalty branch: the word for the new pc is valid in the very next cycle.
//    - Arithmetic is modulo 2**PSIZE: pc=2**PSIZE-1 with incr wraps to 0. A rel offset is added in PSIZE bits, so 2**PSIZE-1 means -1.
//    - Hold (no control asserted, e.g. BAT waiting on switch): pc, prog_addr and instr remain stable.
//    - Jump-to-self (PCabsbranch && baddr==pc, or PCrelbranch && baddr==0) -> HALT at next edge.
//  - HALT:
//    - pc frozen, prog_addr=pc.
//    - instr=NOP, ivalid=0, halted=1; decoder controls are ignored.
//  - Multiple controls asserted simultaneously: resolved strictly by the priority above; not an error.
//  - No X may propagate to instr or opcode in FILL or HALT, regardless of prog_data.
// CONFIGURATION
//  ICOUNT_EN: when defined, adds output port icount [15:0].
//    - icount counts cycles with ivalid=1, cleared by reset.
//    - Saturates at 16'hFFFF, no wrap.
//    - Frozen in HALT.
//  Without ICOUNT_EN: the port and counter are absent; all other behaviour is identical.
// TESTING
//  1 Reset pulse, then ROM mem[0]=16'h1234: cycle 1 gives opcode=4'hF, ivalid=0, pc=0. Cycle 2 gives instr=16'h1234, ivalid=1, pc=0.
//  2 PCincr held for 4 cycles from pc=0: pc=1,2,3,4 and prog_addr leads pc by one. PSIZE=6, pc=63 + PCincr -> pc=0.
//  3 pc=3, PCrelbranch, baddr=6'b111110 -> pc=1 next cycle. pc=2, PCabsbranch, baddr=40 -> pc=40, instr=mem[40] the next cycle. Both controls asserted with baddr=5 -> abs wins (pc=5).
//  4 No control asserted for 3 cycles at pc=7 (BAT hold): pc=7, instr=mem[7] stable, ivalid=1 throughout.
//  5 pc=9, PCabsbranch, baddr=9: next cycle halted=1, ivalid=0, opcode=4'hF. PCincr then has no effect. Reset mid-HALT -> FILL, pc=0, halted=0.
//  6 With ICOUNT_EN: run 5 valid instrs then halt -> icount=5 and stays 5. Force icount=16'hFFFE, run 3 -> icount=16'hFFFF.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage of the picoMIPS core.
// The block drives the synchronous program ROM address and presents the
// fetched word and its opcode to the decoder. It moves through the states
// FILL -> RUN -> HALT. HALT is left only by reset.
// The optional macro ICOUNT_EN adds a 16-bit saturating count of valid
// instruction cycles on port icount.
//
// Handshake note: there is no valid/ready flow control here. The ROM always
// answers one cycle after it receives an address. ivalid qualifies instr in
// every cycle, and the decoder never back-pressures this stage. A stall is
// expressed by holding the PC (no control asserted).
module pc_fetch_unit #(
  parameter int PSIZE = 6,
  parameter int ISIZE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCincr,
  input  logic             PCabsbranch,
  input  logic             PCrelbranch,
  input  logic [PSIZE-1:0] baddr,
  input  logic [ISIZE-1:0] prog_data,
  output logic [PSIZE-1:0] prog_addr,
  output logic [ISIZE-1:0] instr,
  output logic [3:0]       opcode,
  output logic [PSIZE-1:0] pc,
  output logic             ivalid,
  output logic             halted,
  output logic [1:0]       state_dbg
`ifdef ICOUNT_EN
  ,
  output logic [15:0]      icount
`endif
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [ISIZE-1:0] NOP = {4'b1111, {(ISIZE-4){1'b0}}};

  state_t           state_q, state_d;
  logic [PSIZE-1:0] pc_q, pc_d;
  logic [PSIZE-1:0] pc_nxt;
  logic             jump_self;

  // Next-PC candidate from decoder controls: abs > rel > incr > hold.
  always_comb begin
    pc_nxt = pc_q;
    if (PCabsbranch)
      pc_nxt = baddr;
    else if (PCrelbranch)
      pc_nxt = pc_q + baddr;
    else if (PCincr)
      pc_nxt = pc_q + PSIZE'(1);
  end

  // A taken branch that resolves to the current PC is the halt idiom.
  assign jump_self = (PCabsbranch || PCrelbranch) && (pc_nxt == pc_q);

  // State and PC registers. Reset may arrive at any time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FILL;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // FSM next state and fetch outputs. FILL and HALT emit a NOP, so ROM data
  // (possibly X) never reaches instr in those states.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    prog_addr = pc_q;
    instr     = NOP;
    ivalid    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FILL: begin
        prog_addr = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        instr     = prog_data;
        ivalid    = 1'b1;
        prog_addr = pc_nxt;
        pc_d      = pc_nxt;
        if (jump_self)
          state_d = S_HALT;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  assign opcode    = instr[ISIZE-1 -: 4];
  assign pc        = pc_q;
  assign state_dbg = state_q;

`ifdef ICOUNT_EN
  logic [15:0] icount_q, icount_d;

  // The count advances once per valid-instruction cycle and saturates.
  always_comb begin
    icount_d = icount_q;
    if (ivalid && (icount_q != 16'hFFFF))
      icount_d = icount_q + 16'd1;
  end

  // Instruction count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      icount_q <= '0;
    else
      icount_q <= icount_d;
  end

  assign icount = icount_q;
`endif

endmodule
